// File: rtl/soc_status_pkg.sv
// soc_status_pkg: shared constants for the SoC status/event peripheral.
// Register word offsets, halt state encoding and the default halt signature.
package soc_status_pkg;

  // Register word offsets within the peripheral window
  localparam int REG_HALT       = 0;
  localparam int REG_STATUS     = 1;
  localparam int REG_MASK       = 2;
  localparam int REG_CTRL       = 3;
  localparam int REG_COUNT_BASE = 4;

  // Halt state machine encoding
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // Value the CPU writes to HALT to announce program completion
  localparam logic [31:0] DEFAULT_HALT_SIG = 32'hDEADBEEF;

endpackage

// File: rtl/soc_status_evtch.sv
// soc_status_evtch: one event channel. Registers the event level once,
// detects a rising edge (previous 0, current 1), keeps a sticky flag
// (write-1-to-clear, set wins) and a saturating rise counter (clear wins).
module soc_status_evtch
  import soc_status_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             event_in,
  input  logic             sticky_w1c,
  input  logic             cnt_clr,
  output logic             sticky,
  output logic [CNT_W-1:0] count
);

  logic event_q;
  logic rise;

  assign rise = event_in & ~event_q;

  // Edge history, sticky flag and saturating counter
  always_ff @(posedge clock) begin
    if (reset) begin
      event_q <= 1'b0;
      sticky  <= 1'b0;
      count   <= '0;
    end else begin
      event_q <= event_in;
      sticky  <= (sticky & ~sticky_w1c) | rise;
      if (cnt_clr) begin
        count <= '0;
      end else if (rise && (count != {CNT_W{1'b1}})) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/soc_status_ctrl.sv
// soc_status_ctrl: memory-mapped status/event peripheral.
// Latches the CPU halt signature, counts rising edges on NUM_CH event lines
// into sticky flags and saturating counters, and drives LED/IRQ outputs.
// Optional macro STATUS_TIMESTAMP_EN adds a free-running cycle counter whose
// value is captured into TSTAMP (offset REG_COUNT_BASE+NUM_CH) on halt entry.
module soc_status_ctrl
  import soc_status_pkg::*;
#(
  parameter int                NUM_CH   = 4,
  parameter int                ADDR_W   = 4,
  parameter int                DATA_W   = 32,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] HALT_SIG = DATA_W'(DEFAULT_HALT_SIG),
  parameter int                BLINK_W  = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_we_i,
  input  logic              bus_re_i,
  input  logic [ADDR_W-1:0] bus_addr_i,
  input  logic [DATA_W-1:0] bus_wdata_i,
  output logic [DATA_W-1:0] bus_rdata_o,
  output logic              bus_ready_o,
  input  logic [NUM_CH-1:0] event_i,
  output logic              halted_o,
  output logic              irq_o,
  output logic [NUM_CH:0]   led_o
);

  // Bus handshake: a single-cycle we/re strobe sampled on a clock edge is
  // acknowledged by bus_ready_o high for exactly the following cycle; read
  // data is presented with that ready and is 0 otherwise. Strobes may arrive
  // every cycle. With we and re together, the read returns pre-write state.
  // Reset drops any pending acknowledge.

  logic              wr_halt, wr_status, wr_mask, wr_ctrl;
  logic [NUM_CH-1:0] sticky, sticky_w1c, mask;
  logic [CNT_W-1:0]  count [NUM_CH];
  logic              cnt_clr;
  logic [0:0]        state, state_next;
  logic [BLINK_W-1:0] blink_cnt;
  logic [DATA_W-1:0] rd_val;

  assign wr_halt   = bus_we_i && (bus_addr_i == ADDR_W'(REG_HALT));
  assign wr_status = bus_we_i && (bus_addr_i == ADDR_W'(REG_STATUS));
  assign wr_mask   = bus_we_i && (bus_addr_i == ADDR_W'(REG_MASK));
  assign wr_ctrl   = bus_we_i && (bus_addr_i == ADDR_W'(REG_CTRL));

  assign sticky_w1c = wr_status ? bus_wdata_i[NUM_CH-1:0] : '0;
  assign cnt_clr    = wr_ctrl && bus_wdata_i[0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    soc_status_evtch #(.CNT_W(CNT_W)) u_ch (
      .clock      (clock),
      .reset      (reset),
      .event_in   (event_i[i]),
      .sticky_w1c (sticky_w1c[i]),
      .cnt_clr    (cnt_clr),
      .sticky     (sticky[i]),
      .count      (count[i])
    );
  end

  // Halt FSM next state: signature enters HALTED, any other HALT write leaves
  always_comb begin
    state_next = state;
    if (wr_halt) begin
      state_next = (bus_wdata_i == HALT_SIG) ? ST_HALTED : ST_RUN;
    end
  end

  // Halt state register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Blink counter: 0 in RUN and on the entry cycle, free-runs while halted
  always_ff @(posedge clock) begin
    if (reset || (state != ST_HALTED) || (state_next != ST_HALTED)) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Interrupt mask register and registered interrupt
  always_ff @(posedge clock) begin
    if (reset) begin
      mask  <= '0;
      irq_o <= 1'b0;
    end else begin
      if (wr_mask) mask <= bus_wdata_i[NUM_CH-1:0];
      irq_o <= |(sticky & mask);
    end
  end

`ifdef STATUS_TIMESTAMP_EN
  logic [31:0] cyc_cnt, tstamp;

  // Free-running cycle counter; captured on the RUN->HALTED transition
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_cnt <= '0;
      tstamp  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if ((state == ST_RUN) && (state_next == ST_HALTED)) tstamp <= cyc_cnt;
    end
  end
`endif

  // Read mux over current (pre-write) register state
  always_comb begin
    rd_val = '0;
    if (bus_addr_i == ADDR_W'(REG_HALT))   rd_val = DATA_W'(halted_o);
    if (bus_addr_i == ADDR_W'(REG_STATUS)) rd_val = DATA_W'(sticky);
    if (bus_addr_i == ADDR_W'(REG_MASK))   rd_val = DATA_W'(mask);
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus_addr_i == ADDR_W'(REG_COUNT_BASE + i)) rd_val = DATA_W'(count[i]);
    end
`ifdef STATUS_TIMESTAMP_EN
    if (bus_addr_i == ADDR_W'(REG_COUNT_BASE + NUM_CH)) rd_val = DATA_W'(tstamp);
`endif
  end

  // Bus acknowledge and registered read data
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_ready_o <= 1'b0;
      bus_rdata_o <= '0;
    end else begin
      bus_ready_o <= bus_we_i | bus_re_i;
      bus_rdata_o <= bus_re_i ? rd_val : '0;
    end
  end

  assign halted_o = (state == ST_HALTED);
  assign led_o    = {sticky, blink_cnt[BLINK_W-1]};

endmodule

// File: tb/tb_soc_status_ctrl.sv
// tb_soc_status_ctrl: directed and randomized bench for soc_status_ctrl,
// built with CNT_W=4 and BLINK_W=4. A behavioural model tracks the
// peripheral and is compared against the DUT outputs every cycle.
module tb_soc_status_ctrl;

  localparam int          NUM_CH = 4;
  localparam logic [31:0] SIG    = 32'hDEADBEEF;
  localparam int          CMAX   = 15;  // 2^CNT_W-1 with CNT_W=4
  localparam int          HALF   = 8;   // 2^(BLINK_W-1) with BLINK_W=4

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        bus_we_i = 1'b0, bus_re_i = 1'b0;
  logic [3:0]  bus_addr_i = '0;
  logic [31:0] bus_wdata_i = '0;
  logic [31:0] bus_rdata_o;
  logic        bus_ready_o;
  logic [3:0]  event_i = '0;
  logic        halted_o, irq_o;
  logic [4:0]  led_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  soc_status_ctrl #(
    .NUM_CH(NUM_CH), .ADDR_W(4), .DATA_W(32), .CNT_W(4),
    .HALT_SIG(SIG), .BLINK_W(4)
  ) dut (
    .clock(clock), .reset(reset),
    .bus_we_i(bus_we_i), .bus_re_i(bus_re_i),
    .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
    .bus_rdata_o(bus_rdata_o), .bus_ready_o(bus_ready_o),
    .event_i(event_i), .halted_o(halted_o), .irq_o(irq_o), .led_o(led_o)
  );

  // Clock
  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  bit          m_halted, m_irq, m_ready, m_rd_pend;
  int          m_hcyc;          // cycles spent halted since entry
  bit [3:0]    m_sticky, m_mask, m_prev;
  int          m_cnt [NUM_CH];
  int unsigned m_cyc, m_tstamp;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return {31'b0, m_halted};
    if (a == 1) return {28'b0, m_sticky};
    if (a == 2) return {28'b0, m_mask};
    if (a >= 4 && a < 4 + NUM_CH) return 32'(m_cnt[a-4]);
`ifdef STATUS_TIMESTAMP_EN
    if (a == 4 + NUM_CH) return m_tstamp;
`endif
    return 32'd0;
  endfunction

  task automatic model_step();
    logic [31:0] rd;
    bit   [3:0]  rise;
    int          a;
    a = int'(bus_addr_i);
    if (reset) begin
      m_halted = 0; m_irq = 0; m_ready = 0; m_rd_pend = 0; m_hcyc = 0;
      m_sticky = 0; m_mask = 0; m_prev = 0; m_cyc = 0; m_tstamp = 0;
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      exp_q.delete();
      return;
    end
    rd        = model_read(a);
    m_irq     = |(m_sticky & m_mask);
    m_ready   = bus_we_i | bus_re_i;
    m_rd_pend = bus_re_i;
    if (bus_re_i) exp_q.push_back(rd);
    rise   = event_i & ~m_prev;
    m_prev = event_i;
    if (bus_we_i && a == 0) begin
      if (bus_wdata_i == SIG) begin
        if (!m_halted) begin
          m_halted = 1; m_hcyc = 0; m_tstamp = m_cyc;
        end else m_hcyc++;
      end else begin
        m_halted = 0; m_hcyc = 0;
      end
    end else if (m_halted) m_hcyc++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus_we_i && a == 1 && bus_wdata_i[i]) m_sticky[i] = 0;
      if (rise[i]) begin
        m_sticky[i] = 1;
        if (m_cnt[i] < CMAX) m_cnt[i]++;
      end
      if (bus_we_i && a == 3 && bus_wdata_i[0]) m_cnt[i] = 0;
    end
    if (bus_we_i && a == 2) m_mask = bus_wdata_i[3:0];
    m_cyc++;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (cmp_en) begin
      logic [31:0] exp_rd;
      logic        led0;
      exp_rd = 32'd0;
      if (m_ready && m_rd_pend && exp_q.size() > 0) exp_rd = exp_q.pop_front();
      led0 = m_halted && (((m_hcyc / HALF) % 2) == 1);
      check("ready",  32'(bus_ready_o), 32'(m_ready));
      check("rdata",  bus_rdata_o, exp_rd);
      check("halted", 32'(halted_o), 32'(m_halted));
      check("irq",    32'(irq_o), 32'(m_irq));
      check("led",    32'(led_o), 32'({m_sticky, led0}));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus_we_i = 0; bus_re_i = 0; event_i = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clock);
    bus_we_i = 1'b1; bus_addr_i = 4'(a); bus_wdata_i = d;
    @(negedge clock);
    bus_we_i = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    @(negedge clock);
    bus_re_i = 1'b1; bus_addr_i = 4'(a);
    @(negedge clock);
    bus_re_i = 1'b0;
    d = bus_rdata_o;
  endtask

  task automatic pulse(input int ch, input int hold);
    @(negedge clock);
    event_i[ch] = 1'b1;
    repeat (hold) @(negedge clock);
    event_i[ch] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int toggles;
    logic prev_led;

    do_reset();
    cmp_en = 1'b1;

    // Reset state: every offset reads 0
    for (int a = 0; a < 8; a++) begin
      bus_read(a, d);
      check($sformatf("reset_rd%0d", a), d, 32'd0);
    end
    check("reset_halted", 32'(halted_o), 32'd0);
    check("reset_led", 32'(led_o), 32'd0);

    // Halt entry, LED blink, halt exit
    bus_write(0, SIG);
    check("halt_set", 32'(halted_o), 32'd1);
    toggles  = 0;
    prev_led = led_o[0];
    for (int j = 1; j < 32; j++) begin
      @(negedge clock);
      if (led_o[0] !== prev_led) toggles++;
      prev_led = led_o[0];
    end
    check("blink_toggles", 32'(toggles), 32'd3);
    bus_write(0, 32'h1);
    check("halt_clr", 32'(halted_o), 32'd0);
    check("halt_led0", 32'(led_o[0]), 32'd0);

    // Sticky, counter, irq on channel 2
    bus_write(2, 32'h4);
    for (int k = 0; k < 3; k++) pulse(2, 3);
    repeat (2) @(negedge clock);
    bus_read(1, d);
    check("status_ch2", d, 32'h4);
    bus_read(6, d);
    check("count2", d, 32'd3);
    check("model_count2", 32'(m_cnt[2]), 32'd3);
    check("irq_set", 32'(irq_o), 32'd1);
    bus_write(1, 32'h4);
    @(negedge clock);
    check("irq_clr", 32'(irq_o), 32'd0);

    // Simultaneous write and read returns pre-write MASK
    @(negedge clock);
    bus_we_i = 1; bus_re_i = 1; bus_addr_i = 4'd2; bus_wdata_i = 32'hF;
    @(negedge clock);
    bus_we_i = 0; bus_re_i = 0;
    check("we_re_prewrite", bus_rdata_o, 32'h4);
    bus_write(2, 32'h0);

    // Saturation, then counter clear coincident with a rise
    for (int k = 0; k < 20; k++) pulse(0, 1);
    bus_read(4, d);
    check("count0_sat", d, 32'd15);
    @(negedge clock);
    bus_we_i = 1; bus_addr_i = 4'd3; bus_wdata_i = 32'h1; event_i[0] = 1'b1;
    @(negedge clock);
    bus_we_i = 0; event_i[0] = 1'b0;
    bus_read(4, d);
    check("count0_clr_wins", d, 32'd0);
    bus_read(1, d);
    check("status_ch0", d, 32'h1);

    // Rise coincident with W1C on the same bit: set wins
    @(negedge clock);
    bus_we_i = 1; bus_addr_i = 4'd1; bus_wdata_i = 32'h2; event_i[1] = 1'b1;
    @(negedge clock);
    bus_we_i = 0; event_i[1] = 1'b0;
    bus_read(1, d);
    check("status_set_wins", d, 32'h3);
    bus_read(9, d);
    check("unmapped_rd", d, 32'd0);

    // Timestamp offset
    do_reset();
    repeat (100) @(negedge clock);
    bus_we_i = 1; bus_addr_i = 4'd0; bus_wdata_i = SIG;
    @(negedge clock);
    bus_we_i = 0;
    bus_read(4 + NUM_CH, d);
`ifdef STATUS_TIMESTAMP_EN
    check("tstamp", d, 32'd100);
    check("model_tstamp", m_tstamp, 32'd100);
`else
    check("tstamp_absent", d, 32'd0);
`endif

    // Randomized traffic checked every cycle by the scoreboard
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset       = ($urandom_range(0, 499) == 0);
      bus_we_i    = ($urandom_range(0, 2) == 0);
      bus_re_i    = ($urandom_range(0, 2) == 0);
      bus_addr_i  = 4'($urandom_range(0, 9));
      bus_wdata_i = $urandom;
      if (bus_addr_i == 4'd0 && $urandom_range(0, 1) == 1) bus_wdata_i = SIG;
      if (bus_addr_i == 4'd3 && $urandom_range(0, 3) != 0) bus_wdata_i[0] = 1'b0;
      event_i = event_i ^ 4'($urandom & $urandom);
    end
    @(negedge clock);
    reset = 0; bus_we_i = 0; bus_re_i = 0; event_i = '0;
    repeat (3) @(negedge clock);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
